dvi_video_timing_ctrl: RTL and testbench

Video timing controller that sequences the DVI transmitter datapath. It generates hsync, vsync and data-enable, plus pixel-fetch requests with pixel coordinates toward a pixel source (line buffer or framebuffer reader). It then delivers aligned RGB888 video (video_din, video_hsync, video_vsync, video_de) to the TMDS encoder/serializer stage. It runs in the pixel-clock domain and starts and stops only on frame boundaries.

---
 rtl/dvi_video_timing_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_dvi_video_timing_ctrl.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dvi_video_timing_ctrl.sv
// DVI video timing controller: sync/de generation, pixel-fetch requests and a
// three-stage aligned RGB888 output path toward the TMDS encoder.
module dvi_video_timing_ctrl #(
  parameter int          H_SYNC   = 40,
  parameter int          H_BACK   = 220,
  parameter int          H_DISP   = 1280,
  parameter int          H_FRONT  = 110,
  parameter int          V_SYNC   = 5,
  parameter int          V_BACK   = 20,
  parameter int          V_DISP   = 720,
  parameter int          V_FRONT  = 5,
  parameter bit          SYNC_POL = 1'b1,
  parameter logic [23:0] BG_COLOR = 24'h000000
) (
  input  logic        pclk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [23:0] pixel_data,
  input  logic        pixel_valid,
  input  logic        clr_underflow,
  output logic        pixel_req,
  output logic [11:0] pixel_xpos,
  output logic [11:0] pixel_ypos,
  output logic [23:0] video_din,
  output logic        video_hsync,
  output logic        video_vsync,
  output logic        video_de,
  output logic        frame_start,
  output logic        underflow,
  output logic        running
);

  localparam int          H_TOTAL  = H_SYNC + H_BACK + H_DISP + H_FRONT;
  localparam int          V_TOTAL  = V_SYNC + V_BACK + V_DISP + V_FRONT;
  localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST   = 12'(V_TOTAL - 1);
  localparam logic [11:0] H_ACT_LO = 12'(H_SYNC + H_BACK);
  localparam logic [11:0] V_ACT_LO = 12'(V_SYNC + V_BACK);
  localparam logic [11:0] H_DISP_W = 12'(H_DISP);
  localparam logic [11:0] V_DISP_W = 12'(V_DISP);
  localparam logic [11:0] H_SYNC_W = 12'(H_SYNC);
  localparam logic [11:0] V_SYNC_W = 12'(V_SYNC);

  typedef enum logic {IDLE, RUN} state_e;

  state_e      state_q, state_d;
  logic [11:0] hCnt_q, hCnt_d, vCnt_q, vCnt_d;

  logic        inRun, hAct, vAct;
  logic [11:0] hOff, vOff;

  logic        req_d, hs1_d, vs1_d, fs1_d;
  logic [11:0] xpos_d, ypos_d;
  logic        req_q, hs1_q, vs1_q, fs1_q;
  logic [11:0] xpos_q, ypos_q;
  logic        de2_q, hs2_q, vs2_q, fs2_q;
  logic [23:0] din_q;
  logic        hsync_q, vsync_q, de_q, fs_q;
  logic        under_q, under_d;

  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      hCnt_q  <= '0;
      vCnt_q  <= '0;
    end else begin
      state_q <= state_d;
      hCnt_q  <= hCnt_d;
      vCnt_q  <= vCnt_d;
    end
  end

  // enable only matters in IDLE or on the last pixel of a frame, so a
  // mid-frame drop (or drop-and-restore glitch) never truncates a frame.
  always_comb begin
    state_d = state_q;
    hCnt_d  = hCnt_q;
    vCnt_d  = vCnt_q;
    case (state_q)
      IDLE: begin
        hCnt_d = '0;
        vCnt_d = '0;
        if (enable) state_d = RUN;
      end
      RUN: begin
        if (hCnt_q == H_LAST) begin
          hCnt_d = '0;
          if (vCnt_q == V_LAST) begin
            vCnt_d = '0;
            if (!enable) state_d = IDLE;
          end else begin
            vCnt_d = vCnt_q + 12'd1;
          end
        end else begin
          hCnt_d = hCnt_q + 12'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Offset subtraction wraps below the active start, so one unsigned compare
  // covers both bounds and the offset doubles as the pixel coordinate.
  assign inRun  = (state_q == RUN);
  assign hOff   = hCnt_q - H_ACT_LO;
  assign vOff   = vCnt_q - V_ACT_LO;
  assign hAct   = (hOff < H_DISP_W);
  assign vAct   = (vOff < V_DISP_W);

  assign req_d  = inRun & hAct & vAct;
  assign xpos_d = req_d ? hOff : '0;
  assign ypos_d = req_d ? vOff : '0;
  assign hs1_d  = inRun & (hCnt_q < H_SYNC_W);
  assign vs1_d  = inRun & (vCnt_q < V_SYNC_W);
  assign fs1_d  = inRun & (hCnt_q == '0) & (vCnt_q == '0);

  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      req_q  <= 1'b0;
      xpos_q <= '0;
      ypos_q <= '0;
      hs1_q  <= 1'b0;
      vs1_q  <= 1'b0;
      fs1_q  <= 1'b0;
      de2_q  <= 1'b0;
      hs2_q  <= 1'b0;
      vs2_q  <= 1'b0;
      fs2_q  <= 1'b0;
    end else begin
      req_q  <= req_d;
      xpos_q <= xpos_d;
      ypos_q <= ypos_d;
      hs1_q  <= hs1_d;
      vs1_q  <= vs1_d;
      fs1_q  <= fs1_d;
      de2_q  <= req_q;
      hs2_q  <= hs1_q;
      vs2_q  <= vs1_q;
      fs2_q  <= fs1_q;
    end
  end

  // The source answers during the stage-2 cycle, so pixel_valid is only
  // meaningful while de2_q is set.
  always_comb begin
    under_d = under_q;
    if (de2_q && !pixel_valid) under_d = 1'b1;
    else if (clr_underflow)    under_d = 1'b0;
  end

  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      din_q   <= '0;
      de_q    <= 1'b0;
      hsync_q <= ~SYNC_POL;
      vsync_q <= ~SYNC_POL;
      fs_q    <= 1'b0;
      under_q <= 1'b0;
    end else begin
      din_q   <= de2_q ? (pixel_valid ? pixel_data : BG_COLOR) : '0;
      de_q    <= de2_q;
      hsync_q <= hs2_q ? SYNC_POL : ~SYNC_POL;
      vsync_q <= vs2_q ? SYNC_POL : ~SYNC_POL;
      fs_q    <= fs2_q;
      under_q <= under_d;
    end
  end

  assign pixel_req   = req_q;
  assign pixel_xpos  = xpos_q;
  assign pixel_ypos  = ypos_q;
  assign video_din   = din_q;
  assign video_hsync = hsync_q;
  assign video_vsync = vsync_q;
  assign video_de    = de_q;
  assign frame_start = fs_q;
  assign underflow   = under_q;
  assign running     = inRun;

endmodule

// File: tb/tb_dvi_video_timing_ctrl.sv
// Bench for dvi_video_timing_ctrl: a positive- and a negative-sync instance
// share stimulus and are compared every cycle against a frame-position model.
module tb_dvi_video_timing_ctrl;

  localparam int HS = 2, HB = 2, HD = 4, HF = 2;
  localparam int VS = 1, VB = 1, VD = 3, VF = 1;
  localparam int HT = HS + HB + HD + HF;
  localparam int VT = VS + VB + VD + VF;
  localparam int FRAME = HT * VT;
  localparam logic [23:0] BG = 24'hFF00FF;

  logic        pclk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic [23:0] pixel_data = '0;
  logic        pixel_valid = 1'b0;
  logic        clr_underflow = 1'b0;

  logic        reqA, hsA, vsA, deA, fsA, underA, runA;
  logic [11:0] xposA, yposA;
  logic [23:0] dinA;
  logic        reqB, hsB, vsB, deB, fsB, underB, runB;
  logic [11:0] xposB, yposB;
  logic [23:0] dinB;

  int errors = 0;
  int checks = 0;

  // Model: position within the frame (y*HT+x) per cycle, -1 when idle.
  bit          mRun = 1'b0;
  int          mPos = 0;
  int          hist[4] = '{-1, -1, -1, -1};
  bit          mUnder = 1'b0;
  bit          mValid = 1'b0;
  logic [23:0] mData = '0;

  // Source / stimulus controls
  bit          pendReq = 1'b0;
  logic [11:0] pendX = '0, pendY = '0;
  bit          missTarget = 1'b0, randomMiss = 1'b0;
  bit          clrWithMiss = 1'b0, clrRandom = 1'b0;
  logic [11:0] missX = '0, missY = '0;

  dvi_video_timing_ctrl #(
    .H_SYNC(HS), .H_BACK(HB), .H_DISP(HD), .H_FRONT(HF),
    .V_SYNC(VS), .V_BACK(VB), .V_DISP(VD), .V_FRONT(VF),
    .SYNC_POL(1'b1), .BG_COLOR(BG)
  ) dutA (
    .pclk(pclk), .reset_n(reset_n), .enable(enable),
    .pixel_data(pixel_data), .pixel_valid(pixel_valid), .clr_underflow(clr_underflow),
    .pixel_req(reqA), .pixel_xpos(xposA), .pixel_ypos(yposA),
    .video_din(dinA), .video_hsync(hsA), .video_vsync(vsA), .video_de(deA),
    .frame_start(fsA), .underflow(underA), .running(runA)
  );

  dvi_video_timing_ctrl #(
    .H_SYNC(HS), .H_BACK(HB), .H_DISP(HD), .H_FRONT(HF),
    .V_SYNC(VS), .V_BACK(VB), .V_DISP(VD), .V_FRONT(VF),
    .SYNC_POL(1'b0), .BG_COLOR(BG)
  ) dutB (
    .pclk(pclk), .reset_n(reset_n), .enable(enable),
    .pixel_data(pixel_data), .pixel_valid(pixel_valid), .clr_underflow(clr_underflow),
    .pixel_req(reqB), .pixel_xpos(xposB), .pixel_ypos(yposB),
    .video_din(dinB), .video_hsync(hsB), .video_vsync(vsB), .video_de(deB),
    .frame_start(fsB), .underflow(underB), .running(runB)
  );

  always #5 pclk = ~pclk;

  function automatic bit inActive(input int p);
    if (p < 0) return 1'b0;
    return ((p % HT) >= HS + HB) && ((p % HT) < HS + HB + HD) &&
           ((p / HT) >= VS + VB) && ((p / HT) < VS + VB + VD);
  endfunction

  // Reference model advances on the same edges as the DUT.
  always @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      mRun = 1'b0; mPos = 0; mUnder = 1'b0; mValid = 1'b0; mData = '0;
      for (int i = 0; i < 4; i++) hist[i] = -1;
    end else begin
      if (inActive(hist[2]) && !pixel_valid) mUnder = 1'b1;
      else if (clr_underflow)               mUnder = 1'b0;
      mValid  = pixel_valid;
      mData   = pixel_data;
      hist[3] = hist[2];
      hist[2] = hist[1];
      hist[1] = hist[0];
      if (!mRun) begin
        mPos = 0;
        if (enable) mRun = 1'b1;
      end else if (mPos == FRAME - 1) begin
        mPos = 0;
        if (!enable) mRun = 1'b0;
      end else begin
        mPos = mPos + 1;
      end
      hist[0] = mRun ? mPos : -1;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkAll();
    int p1, p3;
    bit req, de, hs, vs;
    logic [23:0] din;
    p1  = hist[1];
    p3  = hist[3];
    req = inActive(p1);
    de  = inActive(p3);
    hs  = (p3 >= 0) && ((p3 % HT) < HS);
    vs  = (p3 >= 0) && ((p3 / HT) < VS);
    din = de ? (mValid ? mData : BG) : 24'h0;
    checkOutput("running",   32'(runA),   32'(mRun));
    checkOutput("pixel_req", 32'(reqA),   32'(req));
    checkOutput("xpos",      32'(xposA),  req ? 32'(p1 % HT - (HS + HB)) : 32'd0);
    checkOutput("ypos",      32'(yposA),  req ? 32'(p1 / HT - (VS + VB)) : 32'd0);
    checkOutput("video_de",  32'(deA),    32'(de));
    checkOutput("video_din", 32'(dinA),   32'(din));
    checkOutput("hsync",     32'(hsA),    32'(hs));
    checkOutput("vsync",     32'(vsA),    32'(vs));
    checkOutput("frame_start", 32'(fsA),  32'(p3 == 0));
    checkOutput("underflow", 32'(underA), 32'(mUnder));
    checkOutput("neg_hsync", 32'(hsB),    32'(!hs));
    checkOutput("neg_vsync", 32'(vsB),    32'(!vs));
    checkOutput("neg_de",    32'(deB),    32'(de));
    checkOutput("neg_din",   32'(dinB),   32'(din));
  endtask

  // Source answers one cycle after each request; outside those cycles it
  // drives random junk that the DUT must ignore.
  task automatic applyStimulus();
    bit miss;
    miss = 1'b0;
    clr_underflow = 1'b0;
    if (pendReq) begin
      if (missTarget && pendX == missX && pendY == missY) miss = 1'b1;
      if (randomMiss && $urandom_range(0, 3) == 0)       miss = 1'b1;
      pixel_valid = !miss;
      pixel_data  = {12'h0, pendX[5:0], pendY[5:0]};
      if (clrWithMiss && miss) clr_underflow = 1'b1;
    end else begin
      pixel_valid = 1'($urandom_range(0, 1));
      pixel_data  = 24'($urandom);
    end
    if (clrRandom && $urandom_range(0, 7) == 0) clr_underflow = 1'b1;
    pendReq = reqA;
    pendX   = xposA;
    pendY   = yposA;
  endtask

  task automatic tick();
    @(negedge pclk);
    checkAll();
    applyStimulus();
  endtask

  task automatic waitPos(input int p);
    for (int k = 0; k < 2 * FRAME && hist[0] != p; k++) tick();
    checkOutput("reach_pos", 32'(hist[0]), 32'(p));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: bench did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int reqCnt, fsLast, stopAt, firstFs;
    $display("[TB] start");
    repeat (3) @(negedge pclk);
    checkAll();
    reset_n = 1'b1;

    reqCnt = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (reqA) reqCnt++;
    end
    checkOutput("idle_req_count", 32'(reqCnt), 32'd0);

    // Run two frames with the pixel at (2,1) withheld each time
    missTarget = 1'b1; missX = 12'd2; missY = 12'd1;
    enable = 1'b1;
    tick();
    checkOutput("running_cycle1", 32'(runA), 32'd1);
    reqCnt = 0; fsLast = -1;
    for (int i = 0; i < 2 * FRAME; i++) begin
      tick();
      if (reqA) reqCnt++;
      if (fsA) begin
        if (fsLast >= 0) checkOutput("fs_period", 32'(i - fsLast), 32'(FRAME));
        fsLast = i;
      end
    end
    checkOutput("req_per_2frames", 32'(reqCnt), 32'(2 * HD * VD));
    missTarget = 1'b0;
    checkOutput("underflow_sticky", 32'(underA), 32'd1);
    clr_underflow = 1'b1;
    tick();
    checkOutput("underflow_cleared", 32'(underA), 32'd0);

    // Miss and clear land in the same cycle
    missTarget = 1'b1; clrWithMiss = 1'b1;
    for (int i = 0; i < FRAME; i++) tick();
    checkOutput("underflow_set_wins", 32'(underA), 32'd1);
    missTarget = 1'b0; clrWithMiss = 1'b0;

    randomMiss = 1'b1; clrRandom = 1'b1;
    for (int i = 0; i < 2 * FRAME; i++) tick();
    randomMiss = 1'b0; clrRandom = 1'b0;
    clr_underflow = 1'b1;
    tick();

    // Enable glitch mid-frame, then a real stop requested at (5,2)
    waitPos(30);
    enable = 1'b0;
    tick(); tick();
    enable = 1'b1;
    waitPos(2 * HT + 5);
    checkOutput("glitch_ignored", 32'(runA), 32'd1);
    enable = 1'b0;
    stopAt = -1;
    for (int k = 1; k <= FRAME; k++) begin
      tick();
      if (!runA && stopAt < 0) stopAt = k;
    end
    checkOutput("stop_latency", 32'(stopAt), 32'(FRAME - (2 * HT + 5)));
    reqCnt = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (reqA || fsA) reqCnt++;
    end
    checkOutput("quiet_after_stop", 32'(reqCnt), 32'd0);

    // Asynchronous reset in the middle of an active line
    enable = 1'b1;
    waitPos(3 * HT + 6);
    tick(); tick();
    #2 reset_n = 1'b0;
    #1;
    checkOutput("rst_req",   32'(reqA),   32'd0);
    checkOutput("rst_xpos",  32'(xposA),  32'd0);
    checkOutput("rst_de",    32'(deA),    32'd0);
    checkOutput("rst_din",   32'(dinA),   32'd0);
    checkOutput("rst_hsync", 32'(hsA),    32'd0);
    checkOutput("rst_vsync", 32'(vsA),    32'd0);
    checkOutput("rst_run",   32'(runA),   32'd0);
    checkOutput("rst_fs",    32'(fsA),    32'd0);
    checkOutput("rst_under", 32'(underA), 32'd0);
    checkOutput("rst_neg_hsync", 32'(hsB), 32'd1);
    checkOutput("rst_neg_vsync", 32'(vsB), 32'd1);
    checkAll();
    @(negedge pclk);
    pendReq = 1'b0;
    reset_n = 1'b1;
    firstFs = -1;
    for (int i = 0; i < 2 * FRAME; i++) begin
      tick();
      if (i == 0) checkOutput("restart_running", 32'(runA), 32'd1);
      if (fsA && firstFs < 0) firstFs = i;
    end
    checkOutput("restart_fs", 32'(firstFs), 32'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
